// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the SAP-2 fetch unit (master) and its memory / control unit (slave).
// Handshake: instr_valid rises once opcode/temp regs hold a complete instruction; they stay frozen
// until instr_ack is seen high on a rising edge, which consumes it. mem_rd_en has no back-pressure:
// read data is presented on mem_data_in exactly one clock after the strobe.
interface instr_fetch_unit_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd_en;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic [1:0]            op_len;
   logic [DATA_WIDTH-1:0] opcode;
   logic [DATA_WIDTH-1:0] temp_1_out;
   logic [DATA_WIDTH-1:0] temp_2_out;
   logic                  instr_valid;
   logic                  instr_ack;
   logic                  pc_load;
   logic [ADDR_WIDTH-1:0] pc_load_value;
   logic                  halt;
   logic [ADDR_WIDTH-1:0] counter_out;
   logic                  halted;
   logic                  illegal_op;

   modport master (
      output mem_addr, mem_rd_en, opcode, temp_1_out, temp_2_out, instr_valid,
             counter_out, halted, illegal_op,
      input  mem_data_in, op_len, instr_ack, pc_load, pc_load_value, halt
   );

   modport slave (
      input  mem_addr, mem_rd_en, opcode, temp_1_out, temp_2_out, instr_valid,
             counter_out, halted, illegal_op,
      output mem_data_in, op_len, instr_ack, pc_load, pc_load_value, halt
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// SAP-2 instruction fetch front-end: owns the PC, reads 1-3 byte instructions, handles jump and halt.
// Optional macro FETCH_ILLEGAL_OP_TRAP_EN: op_len==0 traps into FAULT instead of decoding as 1 byte.
module instr_fetch_unit #(
   parameter int                    ADDR_WIDTH   = 16,
   parameter int                    DATA_WIDTH   = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_unit_if.master bus,
   output logic [3:0]         state_dbg
);

   localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] ZERO_BYTE = '0;

   typedef enum logic [3:0] {
      FETCH_OP       = 4'd0,
      WAIT_OP        = 4'd1,
      CHK_MORE_BYTES = 4'd2,
      FETCH_T1       = 4'd3,
      WAIT_T1        = 4'd4,
      FETCH_T2       = 4'd5,
      WAIT_T2        = 4'd6,
      READY          = 4'd7,
      HALTED         = 4'd8
`ifdef FETCH_ILLEGAL_OP_TRAP_EN
      ,
      FAULT          = 4'd9
`endif
   } state_t;

   state_t state;
   logic   three_byte;

   assign state_dbg = state;

`ifndef FETCH_ILLEGAL_OP_TRAP_EN
   assign bus.illegal_op = 1'b0;
`endif

   // mem_rd_en is raised on the edge entering a FETCH_* state so the strobe and address are
   // visible during that state; the data then lands during the following WAIT_* state.
   // Straight out of reset FETCH_OP is entered with the strobe low, so it spends one cycle arming it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= FETCH_OP;
         three_byte      <= 1'b0;
         bus.counter_out <= RESET_VECTOR;
         bus.mem_addr    <= RESET_VECTOR;
         bus.mem_rd_en   <= 1'b0;
         bus.opcode      <= ZERO_BYTE;
         bus.temp_1_out  <= ZERO_BYTE;
         bus.temp_2_out  <= ZERO_BYTE;
         bus.instr_valid <= 1'b0;
         bus.halted      <= 1'b0;
`ifdef FETCH_ILLEGAL_OP_TRAP_EN
         bus.illegal_op  <= 1'b0;
`endif
      end else begin
         bus.mem_rd_en <= 1'b0;
         case (state)
            FETCH_OP: begin
               if (bus.mem_rd_en) begin
                  bus.counter_out <= bus.counter_out + PC_STEP;
                  state           <= WAIT_OP;
               end else begin
                  bus.mem_rd_en <= 1'b1;
                  bus.mem_addr  <= bus.counter_out;
               end
            end

            WAIT_OP: begin
               bus.opcode <= bus.mem_data_in;
               state      <= CHK_MORE_BYTES;
            end

            CHK_MORE_BYTES: begin
               three_byte <= (bus.op_len == 2'd3);
               if (bus.op_len[1]) begin
                  bus.mem_rd_en <= 1'b1;
                  bus.mem_addr  <= bus.counter_out;
                  state         <= FETCH_T1;
               end
`ifdef FETCH_ILLEGAL_OP_TRAP_EN
               else if (bus.op_len == 2'd0) begin
                  bus.illegal_op <= 1'b1;
                  state          <= FAULT;
               end
`endif
               else begin
                  bus.instr_valid <= 1'b1;
                  state           <= READY;
               end
            end

            FETCH_T1: begin
               bus.counter_out <= bus.counter_out + PC_STEP;
               state           <= WAIT_T1;
            end

            WAIT_T1: begin
               bus.temp_1_out <= bus.mem_data_in;
               if (three_byte) begin
                  bus.mem_rd_en <= 1'b1;
                  bus.mem_addr  <= bus.counter_out;
                  state         <= FETCH_T2;
               end else begin
                  bus.instr_valid <= 1'b1;
                  state           <= READY;
               end
            end

            FETCH_T2: begin
               bus.counter_out <= bus.counter_out + PC_STEP;
               state           <= WAIT_T2;
            end

            WAIT_T2: begin
               bus.temp_2_out  <= bus.mem_data_in;
               bus.instr_valid <= 1'b1;
               state           <= READY;
            end

            // Halt wins over ack and jump; a jump with ack redirects the very next fetch.
            READY: begin
               if (bus.halt) begin
                  bus.halted <= 1'b1;
                  state      <= HALTED;
               end else begin
                  if (bus.pc_load) begin
                     bus.counter_out <= bus.pc_load_value;
                  end
                  if (bus.instr_ack) begin
                     bus.instr_valid <= 1'b0;
                     bus.mem_rd_en   <= 1'b1;
                     bus.mem_addr    <= bus.pc_load ? bus.pc_load_value : bus.counter_out;
                     state           <= FETCH_OP;
                  end
               end
            end

            HALTED: begin
               state <= HALTED;
            end

`ifdef FETCH_ILLEGAL_OP_TRAP_EN
            FAULT: begin
               state <= FAULT;
            end
`endif

            default: begin
               state <= FETCH_OP;
            end
         endcase
      end
   end

endmodule
